universal_shift_engine: RTL
===========================

Name: universal_shift_engine

Overview:
Parametrised successor to the team's N-bit bidirectional shift register. Holds an N-bit word and performs a multi-bit shift, rotate or arithmetic operation one bit per clock. The operation is launched by a start/busy/done handshake. Sits between parallel data sources and serial/bit-manipulation logic in the assignment datapath.

Parameters:
N, 8, register width in bits (N >= 2)
AW, $clog2(N)+1, width of the shift-amount input; must be able to represent the value N

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
load_en  input  1  parallel load request; honoured only in IDLE
parallel_in  input  N  word loaded when load_en is honoured
start  input  1  operation launch request; honoured only in IDLE
mode  input  3  operation select, sampled on an accepted start
amount  input  AW  number of single-bit steps, sampled on an accepted start
serial_in  input  1  fill bit for the serial modes, sampled on every step edge
parallel_out  output  N  current register contents
serial_out  output  1  bit shifted or rotated out on the most recent step
busy  output  1  high while steps remain
done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Reset (reset=0, asynchronous): parallel_out=0, serial_out=0, busy=0, done=0, state=IDLE, internal step count=0. Reset is honoured immediately, including mid-operation; the operation is abandoned.
- Mode encoding:
  - 000 logical left, fill 0
  - 001 logical right, fill 0
  - 010 rotate left
  - 011 rotate right
  - 100 arithmetic right, MSB replicated
  - 101 serial left, serial_in enters at bit 0
  - 110 serial right, serial_in enters at bit N-1
  - 111 reserved; start with mode 111 is ignored (no busy, no done)
- States: IDLE and SHIFT.
- IDLE, priority order:
  - load_en=1: parallel_out <= parallel_in, serial_out <= 0. A start in the same cycle is dropped.
  - Else start=1 with a valid mode: latch mode and eff_amt = min(amount, N).
    - eff_amt=0: stay in IDLE, done=1 for one cycle, data unchanged.
    - Otherwise: go to SHIFT, busy=1, remaining=eff_amt. No data change on this accept edge.
- SHIFT, on each edge:
  - Perform one step per the latched mode.
  - serial_out <= the bit that left the register: bit N-1 for left modes, bit 0 for right modes. Rotates report the wrapped bit.
  - Decrement remaining.
  - When remaining goes 1->0: busy <= 0, done <= 1, return to IDLE.
- Latency: busy is high for exactly eff_amt cycles after the accept edge. done is high during the cycle after the final step edge.
- In SHIFT, start, load_en, mode and amount are ignored.
- done is never high in the same cycle as busy. done deasserts after one cycle unless a new zero-amount start is accepted.
- Arithmetic right by N yields all copies of the original MSB. Logical shift by N yields 0.
- All arithmetic is unsigned. Clamping uses the full AW-bit compare, so amount values > N never wrap.

Test Plan:
- Load 8'b10110101; start mode=010, amount=3 -> busy high 3 cycles; parallel_out passes 01101011, 11010110, 10101101; serial_out=1; done pulses 1 cycle after the last step.
- Load 8'b10110101; mode=100, amount=2 -> 11011010 then 11101101; serial_out=0; done once.
- Load 8'b10110101; mode=110, amount=3, serial_in=1,0,1 on the step edges -> 11011010, 01101101, 10110110; serial_out=1.
- mode=000, amount=12 (clamped) on 8'hFF -> busy exactly 8 cycles, result 8'h00. amount=0 -> done next cycle, busy never high, data unchanged.
- During busy, pulse start and load_en with parallel_in=8'h0F -> both ignored; the operation completes unchanged. mode=111 start in IDLE -> no busy, no done.
- Assert reset low mid-SHIFT, between clock edges -> parallel_out=0, busy=0, done=0 immediately. After release, a new load/start works normally.

Source files
------------

// File: rtl/universal_shift_engine.sv
// Shift/rotate engine: an N-bit word is shifted one bit per clock for a clamped
// number of steps, launched by start and tracked with busy/done.
module universal_shift_engine #(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [N-1:0]  parallel_in,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic          serial_in,
  output logic [N-1:0]  parallel_out,
  output logic          serial_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [AW-1:0] N_AW = AW'(N);

  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [N-1:0]  data_d;
  logic          so_d, busy_d, done_d;

  logic [AW-1:0] eff_amt;
  logic          is_left, fill_l, fill_r;
  logic [N-1:0]  step_word;
  logic          step_bit;

  // Compare at full AW width so amounts above N clamp instead of wrapping.
  assign eff_amt = (amount > N_AW) ? N_AW : amount;

  assign is_left = (mode_q == 3'b000) || (mode_q == 3'b010) || (mode_q == 3'b101);

  always_comb begin
    fill_l = 1'b0;
    fill_r = 1'b0;
    case (mode_q)
      3'b010:  fill_l = parallel_out[N-1];
      3'b101:  fill_l = serial_in;
      3'b011:  fill_r = parallel_out[0];
      3'b100:  fill_r = parallel_out[N-1];
      3'b110:  fill_r = serial_in;
      default: ;
    endcase
  end

  assign step_word = is_left ? {parallel_out[N-2:0], fill_l} : {fill_r, parallel_out[N-1:1]};
  assign step_bit  = is_left ? parallel_out[N-1] : parallel_out[0];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    data_d  = parallel_out;
    so_d    = serial_out;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          data_d = parallel_in;
          so_d   = 1'b0;
        end else if (start && mode != 3'b111) begin
          mode_d = mode;
          if (eff_amt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
            rem_d   = eff_amt;
          end
        end
      end
      SHIFT: begin
        data_d = step_word;
        so_d   = step_bit;
        rem_d  = rem_q - 1'b1;
        if (rem_q == AW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= 3'b000;
      rem_q        <= '0;
      parallel_out <= '0;
      serial_out   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rem_q        <= rem_d;
      parallel_out <= data_d;
      serial_out   <= so_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule
